// File: rtl/tdm_tx.sv
// TDM transmitter: four signed channels serialised MSB-first, left-justified, into a 4-slot frame with bick/lrck.
// Latency: a set captured before a frame boundary appears on sdout starting at that boundary's bick fall.
// Backpressure: none; the set is acked when it enters the shift register, and a boundary without a fresh set repeats the last one and raises sticky underrun.
module tdm_tx #(
    parameter int W    = 16,
    parameter int SLOT = 32,
    parameter int DIV  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_valid,
    input  logic [W-1:0] sample_out0,
    input  logic [W-1:0] sample_out1,
    input  logic [W-1:0] sample_out2,
    input  logic [W-1:0] sample_out3,
    output logic         bick,
    output logic         lrck,
    output logic         sdout,
    output logic         sample_ack,
    output logic         underrun
);
    localparam int FB = 4 * SLOT;
    localparam int BW = $clog2(FB);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FB - 1);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [W-1:0]  hold [4];
    logic          pending;
    logic [FB-1:0] shreg;
    logic [FB-1:0] frame_img;
    logic          tc;
    logic          bit_evt;
    logic          boundary;

    // A bit event is the terminal count that drives bick from 1 to 0.
    assign tc       = (div_cnt == DIV_LAST);
    assign bit_evt  = tc && bick;
    assign boundary = bit_evt && (bit_cnt == BIT_LAST);

    // sdout and lrck derive from state that only moves on bit events, so they
    // hold steady across the following bick rising edge.
    assign sdout = shreg[FB-1];
    assign lrck  = (bit_cnt == '0);

    // Divider: bick toggles every DIV clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            bick    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bick    <= ~bick;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Frame bit position; reset value makes the first bick fall frame bit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= BIT_LAST;
        end else if (bit_evt) begin
            bit_cnt <= boundary ? '0 : bit_cnt + BW'(1);
        end
    end

    // Holding register: newest set wins; a valid on the boundary clock is kept for the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) hold[k] <= '0;
            pending <= 1'b0;
        end else if (sample_valid) begin
            hold[0] <= sample_out0;
            hold[1] <= sample_out1;
            hold[2] <= sample_out2;
            hold[3] <= sample_out3;
            pending <= 1'b1;
        end else if (boundary) begin
            pending <= 1'b0;
        end
    end

    // Frame image: slot k carries channel k left-justified, slot 0 sent first.
    // With no fresh set, holding still equals the last set sent, so it is reused as is.
    always_comb begin
        frame_img = '0;
        frame_img[FB-1 -: W]          = hold[0];
        frame_img[FB-1-SLOT -: W]     = hold[1];
        frame_img[FB-1-2*SLOT -: W]   = hold[2];
        frame_img[FB-1-3*SLOT -: W]   = hold[3];
    end

    // Shift register load/shift plus ack pulse and sticky underrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg      <= '0;
            sample_ack <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            sample_ack <= boundary && pending;
            if (boundary) begin
                shreg <= frame_img;
                if (!pending) underrun <= 1'b1;
            end else if (bit_evt) begin
                shreg <= {shreg[FB-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_tdm_tx.sv
// Bench for tdm_tx: frame-level reference model feeds an expected-bit queue; a negedge monitor checks it.
// Latency: model predicts each frame at its boundary clock, monitor pops one entry per bick fall.
// Backpressure: none; stimulus is directed scenarios followed by random sample_valid traffic.
module tb_tdm_tx;
    localparam int W         = 16;
    localparam int SLOT      = 32;
    localparam int DIV       = 2;
    localparam int FB        = 4 * SLOT;
    localparam int FRAME_CLK = FB * 2 * DIV;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sample_valid = 1'b0;
    logic [W-1:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
    logic         bick, lrck, sdout, sample_ack, underrun;

    int checks = 0;
    int errors = 0;

    tdm_tx #(.W(W), .SLOT(SLOT), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .sample_out0(s0), .sample_out1(s1), .sample_out2(s2), .sample_out3(s3),
        .bick(bick), .lrck(lrck), .sdout(sdout),
        .sample_ack(sample_ack), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Reference model state: clocks since reset release and the frame-level view of the producer.
    int           cyc = 0;
    logic [W-1:0] m_hold [4] = '{default: '0};
    logic         m_pend  = 1'b0;
    logic         exp_ack = 1'b0;
    logic         exp_und = 1'b0;
    logic [1:0]   exp_q [$];

    // Frame boundaries fall on clock 2*DIV after release, then once per frame.
    function automatic bit is_bnd(input int e);
        return (e >= 2 * DIV) && (((e - 2 * DIV) % FRAME_CLK) == 0);
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: at each boundary, queue the whole frame that must appear on the wire.
    initial begin
        logic [1:0] ent;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                cyc = 0;
                m_pend = 1'b0;
                exp_ack = 1'b0;
                exp_und = 1'b0;
                for (int k = 0; k < 4; k++) m_hold[k] = '0;
                exp_q.delete();
            end else begin
                cyc = cyc + 1;
                exp_ack = 1'b0;
                if (is_bnd(cyc)) begin
                    for (int k = 0; k < 4; k++) begin
                        for (int b = 0; b < SLOT; b++) begin
                            ent[1] = (k == 0 && b == 0);
                            ent[0] = 1'b0;
                            if (b < W) ent[0] = m_hold[k][W-1-b];
                            exp_q.push_back(ent);
                        end
                    end
                    exp_ack = m_pend;
                    if (!m_pend) exp_und = 1'b1;
                    m_pend = 1'b0;
                end
                if (sample_valid) begin
                    m_hold[0] = s0;
                    m_hold[1] = s1;
                    m_hold[2] = s2;
                    m_hold[3] = s3;
                    m_pend = 1'b1;
                end
            end
        end
    end

    // Monitor: sample on the falling clk edge, away from DUT updates.
    initial begin
        logic       pb, ps, pl;
        logic [1:0] e;
        int         last_rise;
        pb = 1'b0; ps = 1'b0; pl = 1'b0; last_rise = -1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("reset_outputs", {27'd0, bick, lrck, sdout, sample_ack, underrun}, 32'd0);
                pb = 1'b0; ps = 1'b0; pl = 1'b0; last_rise = -1;
            end else begin
                check("bick", {31'd0, bick}, (cyc / DIV) % 2);
                check("sample_ack", {31'd0, sample_ack}, {31'd0, exp_ack});
                check("underrun", {31'd0, underrun}, {31'd0, exp_und});
                if (pb && !bick) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL serial got %0h expected none (queue empty) at %0t", {lrck, sdout}, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("serial", {30'd0, lrck, sdout}, {30'd0, e});
                    end
                end else begin
                    check("stable", {30'd0, lrck, sdout}, {30'd0, pl, ps});
                end
                if (lrck && !pl) begin
                    if (last_rise >= 0) check("lrck_period", cyc - last_rise, FRAME_CLK);
                    last_rise = cyc;
                end
                if (!lrck && pl) check("lrck_width", cyc - last_rise, 2 * DIV);
                pb = bick; ps = sdout; pl = lrck;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d);
        s0 = a; s1 = b; s2 = c; s3 = d;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    // Stop one clock before a boundary so the next sampled edge is the boundary itself.
    task automatic to_boundary();
        int n;
        n = 0;
        while (!is_bnd(cyc + 1) && n < 2 * FRAME_CLK) begin
            tick();
            n++;
        end
    endtask

    // Stimulus.
    initial begin
        int n;
        #2 rst = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        // Directed set before the first boundary.
        send(16'h8001, 16'h0000, 16'h7FFF, 16'hFFFF);
        // Two valids in frame 0: frame 1 must carry only the second.
        repeat (100) tick();
        send(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        repeat (200) tick();
        send(16'hA5A5, 16'h0F0F, 16'hC3C3, 16'h0001);
        // No valid during frame 1: frame 2 repeats the set and underrun sticks.
        to_boundary();
        tick();
        to_boundary();
        tick();
        repeat (50) tick();
        send(16'h4444, 16'h3333, 16'h2222, 16'h1111);
        // Valid exactly on the boundary clock.
        to_boundary();
        send(16'hFEDC, 16'hBA98, 16'h7654, 16'h3210);
        // Random traffic.
        repeat (8 * FRAME_CLK) begin
            if ($urandom_range(0, 399) == 0) send_rand();
            else tick();
        end
        // Reset just after frame bit 70 has been driven.
        n = 0;
        while ((((cyc - 2 * DIV) % FRAME_CLK) != 70 * 2 * DIV) && n < 2 * FRAME_CLK) begin
            tick();
            n++;
        end
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2 * FRAME_CLK + 10) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
